// File: rtl/port_out_fifo_pkg.sv
// Shared sizing constants for the CPU output-port buffer.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

package port_out_fifo_pkg;

    localparam int PORT_DATA_W = `DATA_BITS;
    localparam int PORT_DEPTH  = 8;

endpackage

// File: rtl/defines.sv
// Shared build-wide defines for the CPU and its port peripherals.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

// File: rtl/port_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, contents never reset.
module port_fifo_mem
    import port_out_fifo_pkg::*;
#(
    parameter  int DATA_W = PORT_DATA_W,
    parameter  int DEPTH  = PORT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/port_out_fifo.sv
// Output-port byte buffer between OUT instructions and a valid/ready sink; drops and flags pushes when full.
module port_out_fifo
    import port_out_fifo_pkg::*;
#(
    parameter  int DATA_W = PORT_DATA_W,
    parameter  int DEPTH  = PORT_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop, push_ok, drop;
    logic [DATA_W-1:0] rdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A full buffer still takes a push in the same cycle the sink frees a slot.
    assign pop     = out_valid && out_ready;
    assign push_ok = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;

    // Stale array contents stay hidden while empty, so the port reads 0 after reset.
    assign out_data = out_valid ? rdata : '0;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

    port_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push_ok && !reset),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

endmodule
